// File: rtl/fir_sample_feeder_pkg.sv
// fir_sample_feeder_pkg
// Shared definitions for the FIR sample feeder slice: FSM state encoding,
// sample/accumulator widths, tap count and the packed tap-vector type used
// by both the coefficient bank and the feeder top.
package fir_sample_feeder_pkg;

    localparam int SAMPLE_W = 8;
    localparam int ACC_W    = 10;
    localparam int TAPS     = 4;
    localparam int COEF_AW  = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } feeder_state_t;

    typedef logic [SAMPLE_W-1:0] sample_t;

    // Element 0 is the newest sample / coefficient h_0.
    typedef sample_t [TAPS-1:0] tap_vec_t;

endpackage

// File: rtl/fir_coef_bank.sv
// fir_coef_bank
// 4x8 coefficient register file with a single write port. All entries are
// visible in parallel so the feeder can snapshot the whole bank at once.
//   clk, rst    : clock and asynchronous active-high reset
//   we          : write strobe, accepted in any feeder state
//   addr, wdata : write index (0..3) and Q1.7 coefficient value
//   coefs       : current bank contents, coefs[0] = h_0
module fir_coef_bank
    import fir_sample_feeder_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               we,
    input  logic [COEF_AW-1:0] addr,
    input  sample_t            wdata,
    output tap_vec_t           coefs
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            coefs <= '0;
        end else if (we) begin
            coefs[addr] <= wdata;
        end
    end

endmodule

// File: rtl/fir_sample_feeder.sv
// fir_sample_feeder
// Feeds a 4-tap delay line and a snapshot of the coefficient bank to an
// external MAC, waits (bounded by TIMEOUT) for its result and holds that
// result on a valid/ready output until it is taken.
//   clk, rst                     : clock, asynchronous active-high reset
//   in_valid/in_ready/in_data    : upstream Q1.7 sample handshake
//   coef_we/coef_addr/coef_wdata : coefficient bank write port
//   mac_enable                   : high exactly while waiting for the MAC
//   h_0..h_3, data_0..data_3     : active coefficients and taps to the MAC
//   mac_done/mac_data_out        : MAC result strobe and value
//   y_valid/y_ready/y_data       : downstream result handshake
//   timeout_err                  : sticky, MAC did not answer in time
module fir_sample_feeder
    import fir_sample_feeder_pkg::*;
#(
    parameter int unsigned TIMEOUT = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [SAMPLE_W-1:0] in_data,
    input  logic               coef_we,
    input  logic [COEF_AW-1:0] coef_addr,
    input  logic [SAMPLE_W-1:0] coef_wdata,
    output logic               mac_enable,
    output logic [SAMPLE_W-1:0] h_0,
    output logic [SAMPLE_W-1:0] h_1,
    output logic [SAMPLE_W-1:0] h_2,
    output logic [SAMPLE_W-1:0] h_3,
    output logic [SAMPLE_W-1:0] data_0,
    output logic [SAMPLE_W-1:0] data_1,
    output logic [SAMPLE_W-1:0] data_2,
    output logic [SAMPLE_W-1:0] data_3,
    input  logic               mac_done,
    input  logic [ACC_W-1:0]   mac_data_out,
    output logic               y_valid,
    input  logic               y_ready,
    output logic [ACC_W-1:0]   y_data,
    output logic               timeout_err
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

    feeder_state_t    state;
    tap_vec_t         taps;
    tap_vec_t         h_act;
    tap_vec_t         bank;
    logic [CNT_W-1:0] wait_cnt;

    fir_coef_bank u_coef_bank (
        .clk   (clk),
        .rst   (rst),
        .we    (coef_we),
        .addr  (coef_addr),
        .wdata (coef_wdata),
        .coefs (bank)
    );

    assign in_ready = (state == IDLE);

    assign data_0 = taps[0];
    assign data_1 = taps[1];
    assign data_2 = taps[2];
    assign data_3 = taps[3];
    assign h_0    = h_act[0];
    assign h_1    = h_act[1];
    assign h_2    = h_act[2];
    assign h_3    = h_act[3];

    // wait_cnt holds the number of RUN cycles elapsed including the current
    // one, so it is loaded with 1 on acceptance. Checking mac_done before the
    // limit makes a result on the final allowed cycle count as success.
    // The bank snapshot uses the pre-edge bank, so a write on the acceptance
    // edge only affects the following sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            mac_enable  <= 1'b0;
            y_valid     <= 1'b0;
            y_data      <= '0;
            timeout_err <= 1'b0;
            taps        <= '0;
            h_act       <= '0;
            wait_cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        taps       <= {taps[TAPS-2:0], in_data};
                        h_act      <= bank;
                        wait_cnt   <= CNT_W'(1);
                        mac_enable <= 1'b1;
                        state      <= RUN;
                    end
                end
                RUN: begin
                    if (mac_done) begin
                        y_data     <= mac_data_out;
                        y_valid    <= 1'b1;
                        mac_enable <= 1'b0;
                        wait_cnt   <= '0;
                        state      <= HOLD;
                    end else if (wait_cnt == TIMEOUT_CNT) begin
                        timeout_err <= 1'b1;
                        mac_enable  <= 1'b0;
                        wait_cnt    <= '0;
                        state       <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                HOLD: begin
                    if (y_ready) begin
                        y_valid <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fir_sample_feeder.sv
// tb_fir_sample_feeder
// Directed bench for fir_sample_feeder with a behavioural MAC stub and a
// filter model (sample history, coefficient bank, snapshot coefficients).
module tb_fir_sample_feeder;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       coef_we;
    logic [1:0] coef_addr;
    logic [7:0] coef_wdata;
    logic       mac_enable;
    logic [7:0] h_0, h_1, h_2, h_3;
    logic [7:0] data_0, data_1, data_2, data_3;
    logic       mac_done;
    logic [9:0] mac_data_out;
    logic       y_valid;
    logic       y_ready;
    logic [9:0] y_data;
    logic       timeout_err;

    int checks = 0;
    int errors = 0;

    // MAC stub controls
    int mac_cnt;
    int mac_lat = 5;
    bit mac_never = 0;
    bit stray = 0;

    // filter model
    int         model_taps[4];
    int         model_bank[4];
    int         model_h[4];
    logic [9:0] model_y;
    bit         check_on = 0;

    fir_sample_feeder #(.TIMEOUT(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .coef_we      (coef_we),
        .coef_addr    (coef_addr),
        .coef_wdata   (coef_wdata),
        .mac_enable   (mac_enable),
        .h_0          (h_0),
        .h_1          (h_1),
        .h_2          (h_2),
        .h_3          (h_3),
        .data_0       (data_0),
        .data_1       (data_1),
        .data_2       (data_2),
        .data_3       (data_3),
        .mac_done     (mac_done),
        .mac_data_out (mac_data_out),
        .y_valid      (y_valid),
        .y_ready      (y_ready),
        .y_data       (y_data),
        .timeout_err  (timeout_err)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    function automatic int sx(input logic [7:0] v);
        return int'($signed(v));
    endfunction

    // Q1.7 x Q1.7 products summed, rescaled back to 7 fractional bits.
    function automatic logic [9:0] filterSum(input int c0, input int c1, input int c2, input int c3,
                                             input int d0, input int d1, input int d2, input int d3);
        int acc;
        acc = c0 * d0 + c1 * d1 + c2 * d2 + c3 * d3;
        acc = acc >>> 7;
        return acc[9:0];
    endfunction

    task automatic checkOutput(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // MAC stub: answers mac_lat cycles after mac_enable rises, from the taps
    // and coefficients the feeder presents. Drives 2 time units after the edge.
    initial begin
        mac_done = 0;
        mac_data_out = '0;
        mac_cnt = 0;
        forever begin
            @(posedge clk);
            #2;
            if (mac_enable) mac_cnt++;
            else mac_cnt = 0;
            mac_done = stray || (mac_enable && !mac_never && mac_cnt == mac_lat);
            if (stray) mac_data_out = 10'h155;
            else if (mac_enable && mac_cnt == mac_lat)
                mac_data_out = filterSum(sx(h_0), sx(h_1), sx(h_2), sx(h_3),
                                         sx(data_0), sx(data_1), sx(data_2), sx(data_3));
        end
    end

    // Per-cycle comparison against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (check_on && !rst) begin
                checkOutput("tap0", sx(data_0), model_taps[0]);
                checkOutput("tap1", sx(data_1), model_taps[1]);
                checkOutput("tap2", sx(data_2), model_taps[2]);
                checkOutput("tap3", sx(data_3), model_taps[3]);
                checkOutput("h0", sx(h_0), model_h[0]);
                checkOutput("h1", sx(h_1), model_h[1]);
                checkOutput("h2", sx(h_2), model_h[2]);
                checkOutput("h3", sx(h_3), model_h[3]);
                checkOutput("busy_not_ready", int'((mac_enable || y_valid) && in_ready), 0);
                checkOutput("en_and_valid", int'(mac_enable && y_valid), 0);
                if (y_valid) checkOutput("y_model", int'(y_data), int'(model_y));
            end
        end
    end

    task automatic clearModel();
        for (int i = 0; i < 4; i++) begin
            model_taps[i] = 0;
            model_bank[i] = 0;
            model_h[i] = 0;
        end
        model_y = '0;
    endtask

    // Called just after a rising edge; returns just after the edge that
    // performed the sample acceptance and/or coefficient write.
    task automatic applyStimulus(input bit do_sample, input logic [7:0] s,
                                 input bit do_coef, input logic [1:0] a, input logic [7:0] w);
        int n;
        n = 0;
        if (do_sample) begin
            while (!in_ready && n < 100) begin
                @(posedge clk);
                #1;
                n++;
            end
            if (n >= 100) checkOutput("in_ready_wait", int'(in_ready), 1);
        end
        in_valid   = do_sample;
        in_data    = s;
        coef_we    = do_coef;
        coef_addr  = a;
        coef_wdata = w;
        @(posedge clk);
        if (do_sample) begin
            for (int i = 3; i > 0; i--) model_taps[i] = model_taps[i-1];
            model_taps[0] = sx(s);
            for (int i = 0; i < 4; i++) model_h[i] = model_bank[i];
            model_y = filterSum(model_h[0], model_h[1], model_h[2], model_h[3],
                                model_taps[0], model_taps[1], model_taps[2], model_taps[3]);
        end
        if (do_coef) model_bank[a] = sx(w);
        #1;
        in_valid = 0;
        coef_we  = 0;
    endtask

    task automatic waitResult(input string name, input logic [9:0] exp);
        int n;
        n = 0;
        while (!y_valid && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput({name, "_valid"}, int'(y_valid), 1);
        checkOutput(name, int'(y_data), int'(exp));
        @(posedge clk);
        #1;
    endtask

    initial begin
        int cyc;
        bit saw_y;
        rst = 1;
        in_valid = 0;
        in_data = '0;
        coef_we = 0;
        coef_addr = '0;
        coef_wdata = '0;
        y_ready = 1;
        clearModel();

        // reset state
        #1;
        checkOutput("rst_mac_enable", int'(mac_enable), 0);
        checkOutput("rst_y_valid", int'(y_valid), 0);
        checkOutput("rst_y_data", int'(y_data), 0);
        checkOutput("rst_timeout_err", int'(timeout_err), 0);
        checkOutput("rst_taps", int'({data_0, data_1, data_2, data_3}), 0);
        checkOutput("rst_h", int'({h_0, h_1, h_2, h_3}), 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 0;
        check_on = 1;
        @(posedge clk);
        #1;
        checkOutput("rst_in_ready", int'(in_ready), 1);

        // impulse response with a flat 0.5 bank
        for (int i = 0; i < 4; i++) applyStimulus(0, 8'h00, 1, 2'(i), 8'h40);
        applyStimulus(1, 8'h40, 0, 2'd0, 8'h00);
        waitResult("impulse_0", 10'h020);
        for (int i = 1; i < 4; i++) begin
            applyStimulus(1, 8'h00, 0, 2'd0, 8'h00);
            waitResult("impulse_n", 10'h020);
        end
        applyStimulus(1, 8'h00, 0, 2'd0, 8'h00);
        waitResult("impulse_zero", 10'h000);

        // fill all taps with 0.5, then push -0.5
        applyStimulus(1, 8'h40, 0, 2'd0, 8'h00);
        waitResult("full_1", 10'h020);
        applyStimulus(1, 8'h40, 0, 2'd0, 8'h00);
        waitResult("full_2", 10'h040);
        applyStimulus(1, 8'h40, 0, 2'd0, 8'h00);
        waitResult("full_3", 10'h060);
        applyStimulus(1, 8'h40, 0, 2'd0, 8'h00);
        waitResult("full_4", 10'h080);
        applyStimulus(1, 8'hC0, 0, 2'd0, 8'h00);
        waitResult("full_neg", 10'h040);

        // coefficient write while a sample is in flight
        applyStimulus(1, 8'h10, 0, 2'd0, 8'h00);
        applyStimulus(0, 8'h00, 1, 2'd2, 8'h7F);
        checkOutput("coef_run_h2_kept", int'(h_2), 8'h40);
        waitResult("coef_run_y", 10'h028);
        applyStimulus(1, 8'h00, 0, 2'd0, 8'h00);
        checkOutput("coef_next_h2", int'(h_2), 8'h7F);
        waitResult("coef_next_y", 10'h3E8);

        // write coinciding with acceptance: h takes the old value
        applyStimulus(1, 8'h00, 1, 2'd0, 8'h20);
        checkOutput("coincide_h0_old", int'(h_0), 8'h40);
        waitResult("coincide_y", model_y);
        applyStimulus(1, 8'h08, 0, 2'd0, 8'h00);
        checkOutput("coincide_h0_new", int'(h_0), 8'h20);
        waitResult("coincide_next_y", model_y);

        // backpressure: result held, input ignored
        y_ready = 0;
        applyStimulus(1, 8'h40, 0, 2'd0, 8'h00);
        cyc = 0;
        while (!y_valid && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        for (int i = 0; i < 10; i++) begin
            in_valid = 1;
            in_data  = 8'h55;
            @(posedge clk);
            #1;
            checkOutput("bp_y_valid", int'(y_valid), 1);
            checkOutput("bp_y_data", int'(y_data), int'(model_y));
            checkOutput("bp_in_ready", int'(in_ready), 0);
        end
        in_valid = 0;
        y_ready  = 1;
        @(posedge clk);
        #1;
        checkOutput("bp_release_in_ready", int'(in_ready), 1);
        checkOutput("bp_release_y_valid", int'(y_valid), 0);

        // stray mac_done in IDLE is ignored
        stray = 1;
        @(posedge clk);
        #1;
        stray = 0;
        @(posedge clk);
        #1;
        checkOutput("stray_y_valid", int'(y_valid), 0);
        checkOutput("stray_in_ready", int'(in_ready), 1);
        checkOutput("stray_mac_enable", int'(mac_enable), 0);

        // mac_done on the last allowed cycle is a success
        mac_lat = 8;
        applyStimulus(1, 8'h20, 0, 2'd0, 8'h00);
        waitResult("edge_lat8_y", model_y);
        checkOutput("edge_lat8_no_err", int'(timeout_err), 0);
        mac_lat = 5;

        // MAC never answers
        mac_never = 1;
        applyStimulus(1, 8'h11, 0, 2'd0, 8'h00);
        cyc = 0;
        saw_y = 0;
        for (int i = 0; i < 30; i++) begin
            if (mac_enable) cyc++;
            if (y_valid) saw_y = 1;
            @(posedge clk);
            #1;
        end
        checkOutput("to_enable_cycles", cyc, 8);
        checkOutput("to_err", int'(timeout_err), 1);
        checkOutput("to_no_y_valid", int'(saw_y), 0);
        checkOutput("to_in_ready", int'(in_ready), 1);
        mac_never = 0;

        // normal operation afterwards, error stays sticky
        applyStimulus(1, 8'h40, 0, 2'd0, 8'h00);
        waitResult("post_to_y", model_y);
        checkOutput("post_to_err_sticky", int'(timeout_err), 1);

        // reset during RUN cycle 3
        applyStimulus(1, 8'h33, 0, 2'd0, 8'h00);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        checkOutput("pre_rst_mac_enable", int'(mac_enable), 1);
        rst = 1;
        clearModel();
        #1;
        checkOutput("midrst_mac_enable", int'(mac_enable), 0);
        checkOutput("midrst_y_valid", int'(y_valid), 0);
        checkOutput("midrst_y_data", int'(y_data), 0);
        checkOutput("midrst_timeout_err", int'(timeout_err), 0);
        checkOutput("midrst_taps", int'({data_0, data_1, data_2, data_3}), 0);
        checkOutput("midrst_h", int'({h_0, h_1, h_2, h_3}), 0);
        @(posedge clk);
        #1;
        rst = 0;
        saw_y = 0;
        cyc = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (y_valid) saw_y = 1;
            if (mac_enable) cyc++;
        end
        checkOutput("midrst_no_y_valid", int'(saw_y), 0);
        checkOutput("midrst_no_enable", cyc, 0);
        checkOutput("midrst_in_ready", int'(in_ready), 1);

        // bank was cleared: any sample filters to zero
        applyStimulus(1, 8'h7F, 0, 2'd0, 8'h00);
        waitResult("post_rst_y", 10'h000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fir_sample_feeder.md
FIR_SAMPLE_FEEDER -- requirements
Module: fir_sample_feeder

Interface
REQ-001 Parameter: TIMEOUT, default 8, maximum cycles to wait for mac_done after mac_enable rises.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous reset, active-high.
REQ-004 in_valid  input  1  upstream sample valid.
REQ-005 in_ready  output  1  feeder can accept a sample.
REQ-006 in_data  input  8  Q1.7 two's-complement sample.
REQ-007 coef_we  input  1  coefficient write strobe.
REQ-008 coef_addr  input  2  coefficient index 0..3.
REQ-009 coef_wdata  input  8  Q1.7 coefficient value.
REQ-010 mac_enable  output  1  enable to the downstream MAC.
REQ-011 h_0..h_3  output  8 each  active coefficients to the MAC.
REQ-012 data_0..data_3  output  8 each  delay-line taps, data_0 newest.
REQ-013 mac_done  input  1  MAC result-ready pulse.
REQ-014 mac_data_out  input  10  MAC accumulated result.
REQ-015 y_valid  output  1  filter output valid.
REQ-016 y_ready  input  1  downstream accepts y_data.
REQ-017 y_data  output  10  captured filter result.
REQ-018 timeout_err  output  1  sticky: mac_done not seen within TIMEOUT.

Function
REQ-019 FSM states SHALL be IDLE, RUN, HOLD; in_ready SHALL be 1 only in IDLE.
REQ-020 In IDLE, in_valid=1 SHALL accept: data_3<=data_2, data_2<=data_1, data_1<=data_0, data_0<=in_data; active h_0..h_3 <= coefficient bank; state->RUN; mac_enable<=1.
REQ-021 mac_enable SHALL be 1 exactly while in RUN, registered, with no glitch.
REQ-022 In RUN, mac_done=1 SHALL capture y_data<=mac_data_out, clear mac_enable, and go to HOLD on the same edge.
REQ-023 In RUN, a wait counter SHALL count cycles since entry; if it reaches TIMEOUT without mac_done, set timeout_err=1, clear mac_enable, and return to IDLE without asserting y_valid.
REQ-024 mac_done arriving on the same cycle the counter reaches TIMEOUT SHALL count as success; timeout_err SHALL remain unchanged.
REQ-025 In HOLD, y_valid SHALL be 1 and y_data stable; y_valid&&y_ready SHALL return the FSM to IDLE next cycle.
REQ-026 mac_done outside RUN SHALL be ignored.
REQ-027 Coefficient bank writes (coef_we) SHALL be accepted in any state, written at coef_addr; h_0..h_3 change only at sample acceptance, so mid-run writes apply to the next sample.
REQ-028 A coef_we write coinciding with sample acceptance SHALL update the bank; the h outputs SHALL take the pre-write bank value.
REQ-029 Nominal throughput: one sample per 7 cycles with the standard MAC (accept, 5 MAC cycles, 1 HOLD cycle with y_ready=1).
REQ-030 The feeder SHALL NOT modify sample or result values; y_data width SHALL be 10 bits, passed through.

Reset
REQ-031 rst=1 SHALL immediately force: state IDLE; in_ready=1 after release; mac_enable=0; y_valid=0; y_data=0; timeout_err=0; data_0..data_3=0; h_0..h_3=0; bank=0; wait counter=0.
REQ-032 Reset mid-RUN or mid-HOLD SHALL discard the in-flight result with no y_valid pulse.
REQ-033 timeout_err SHALL be cleared only by rst.

Structure
REQ-034 A shared package SHALL hold the FSM state encoding, the sample width (8), the accumulator width (10), and the tap count (4).
REQ-035 The coefficient bank (4x8 register file with write port) SHALL be sub-module fir_coef_bank; the FSM and delay line SHALL stay in the top module.

Verification
REQ-036 Impulse: bank all 0x40; feed 0x40 then three 0x00, each with y_ready=1, using a real MAC -> y_data = 0x020 four times, then 0x000 on the fifth (zero) sample.
REQ-037 Full taps: bank all 0x40; feed four 0x40 samples -> 4th y_data=0x080; feed 0xC0 (-0.5) -> y_data=0x040.
REQ-038 Backpressure: hold y_ready=0 for 10 cycles after y_valid -> y_valid and y_data stable, in_ready=0, in_valid ignored; release -> IDLE next cycle.
REQ-039 Timeout: MAC stub never asserts mac_done, TIMEOUT=8 -> mac_enable high for 8 cycles, then low; timeout_err=1; no y_valid; in_ready=1.
REQ-040 Coef write during RUN: write h_2=0x7F mid-run -> current h_2 unchanged; next accepted sample presents h_2=0x7F.
REQ-041 Reset mid-RUN: assert rst at cycle 3 of RUN -> all outputs zero immediately; no y_valid after release.
